// File: rtl/attn_qkv_loader_pkg.sv
// Shared types and geometry for the Q/K/V frame loader in front of the attention block.
// Matrix geometry is fixed here so the loader, counter and interface agree on it.
package attn_pkg;

    localparam int D_W     = 8;
    localparam int SA_C    = 16;
    localparam int DIM     = 16;
    localparam int D_K     = 128;
    localparam int SEG_NUM = D_K / SA_C;
    localparam int BEATS   = 3 * DIM * SEG_NUM;

    localparam int SEG_W   = $clog2(SEG_NUM);
    localparam int ROW_W   = $clog2(DIM);
    localparam int ELEM_W  = $clog2(SA_C);
    localparam int COL_W   = $clog2(D_K);

    typedef enum logic [2:0] {
        S_LOAD  = 3'b001,
        S_START = 3'b010,
        S_WAIT  = 3'b100
    } state_t;

    typedef enum logic [1:0] {
        MAT_Q = 2'd0,
        MAT_K = 2'd1,
        MAT_V = 2'd2
    } mat_sel_t;

endpackage

// File: rtl/attn_qkv_loader_if.sv
// Valid/ready stream of 16-element row segments feeding the Q/K/V loader.
interface attn_qkv_loader_if;
    import attn_pkg::*;

    logic                       vld;
    logic                       rdy;
    logic [0:SA_C-1][D_W-1:0]   data;
    logic                       last;

    modport master (output vld, output data, output last, input rdy);
    modport slave  (input vld, input data, input last, output rdy);

endinterface

// File: rtl/attn_qkv_loader_frame_cnt.sv
// Segment/row/matrix position counters for one Q,K,V frame; segment index runs fastest.
module qkv_frame_cnt
    import attn_pkg::*;
(
    input  logic             I_CLK,
    input  logic             I_ASYN_RSTN,
    input  logic             clr,
    input  logic             adv,
    output logic [SEG_W-1:0] seg_cnt,
    output logic [ROW_W-1:0] row_cnt,
    output mat_sel_t         mat_sel,
    output logic             is_final
);

    logic seg_wrap;
    logic row_wrap;

    assign seg_wrap = (seg_cnt == SEG_W'(SEG_NUM - 1));
    assign row_wrap = (row_cnt == ROW_W'(DIM - 1));
    assign is_final = seg_wrap && row_wrap && (mat_sel == MAT_V);

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            seg_cnt <= '0;
            row_cnt <= '0;
            mat_sel <= MAT_Q;
        end else if (clr) begin
            seg_cnt <= '0;
            row_cnt <= '0;
            mat_sel <= MAT_Q;
        end else if (adv) begin
            seg_cnt <= seg_wrap ? '0 : seg_cnt + SEG_W'(1);
            if (seg_wrap) begin
                row_cnt <= row_wrap ? '0 : row_cnt + ROW_W'(1);
                if (row_wrap) begin
                    case (mat_sel)
                        MAT_Q:   mat_sel <= MAT_K;
                        MAT_K:   mat_sel <= MAT_V;
                        default: mat_sel <= MAT_Q;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/attn_qkv_loader.sv
// Assembles Q, K, V from a segment stream, pulses attention start and holds the
// matrices until attention reports done (V is re-read late, during P*V).
//
// state   | meaning
// S_LOAD  | accepting beats, O_RDY high
// S_START | one-cycle O_ATTN_START pulse, matrices complete
// S_WAIT  | matrices frozen until a rising edge of I_ATTN_DONE
module attn_qkv_loader
    import attn_pkg::*;
(
    input  logic                I_CLK,
    input  logic                I_ASYN_RSTN,
    input  logic                I_SYNC_RSTN,
    attn_qkv_loader_if.slave    s_in,
    output logic [D_W-1:0]      O_MAT_Q [0:DIM-1][0:D_K-1],
    output logic [D_W-1:0]      O_MAT_K [0:DIM-1][0:D_K-1],
    output logic [D_W-1:0]      O_MAT_V [0:DIM-1][0:D_K-1],
    output logic                O_ATTN_START,
    input  logic                I_ATTN_DONE,
    output logic                O_BUSY,
    output logic                O_ERR
);

    state_t             state;
    logic               rdy_q;
    logic               done_d;
    logic [SEG_W-1:0]   seg_cnt;
    logic [ROW_W-1:0]   row_cnt;
    mat_sel_t           mat_sel;
    logic               is_final;

    logic               accept;
    logic               frame_ok;
    logic               frame_bad;
    logic               beat_wr;
    logic               wr_en;
    logic               cnt_clr;

    assign s_in.rdy  = rdy_q;
    assign accept    = s_in.vld && rdy_q;
    assign frame_ok  = accept && is_final && s_in.last;
    // I_LAST must coincide with the final position; any disagreement drops the beat
    assign frame_bad = accept && (is_final ^ s_in.last);
    assign beat_wr   = accept && !is_final && !s_in.last;
    assign wr_en     = beat_wr || frame_ok;
    assign cnt_clr   = !I_SYNC_RSTN || frame_ok || frame_bad;

    qkv_frame_cnt u_frame_cnt (
        .I_CLK       (I_CLK),
        .I_ASYN_RSTN (I_ASYN_RSTN),
        .clr         (cnt_clr),
        .adv         (beat_wr),
        .seg_cnt     (seg_cnt),
        .row_cnt     (row_cnt),
        .mat_sel     (mat_sel),
        .is_final    (is_final)
    );

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < D_K; c++) begin
                    O_MAT_Q[r][c] <= '0;
                    O_MAT_K[r][c] <= '0;
                    O_MAT_V[r][c] <= '0;
                end
            end
        end else if (!I_SYNC_RSTN) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < D_K; c++) begin
                    O_MAT_Q[r][c] <= '0;
                    O_MAT_K[r][c] <= '0;
                    O_MAT_V[r][c] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int e = 0; e < SA_C; e++) begin
                case (mat_sel)
                    MAT_Q:   O_MAT_Q[row_cnt][{seg_cnt, ELEM_W'(e)}] <= s_in.data[e];
                    MAT_K:   O_MAT_K[row_cnt][{seg_cnt, ELEM_W'(e)}] <= s_in.data[e];
                    MAT_V:   O_MAT_V[row_cnt][{seg_cnt, ELEM_W'(e)}] <= s_in.data[e];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            state        <= S_LOAD;
            rdy_q        <= 1'b0;
            O_ATTN_START <= 1'b0;
            O_BUSY       <= 1'b0;
            O_ERR        <= 1'b0;
            done_d       <= 1'b0;
        end else if (!I_SYNC_RSTN) begin
            state        <= S_LOAD;
            rdy_q        <= 1'b0;
            O_ATTN_START <= 1'b0;
            O_BUSY       <= 1'b0;
            O_ERR        <= 1'b0;
            done_d       <= 1'b0;
        end else begin
            done_d       <= I_ATTN_DONE;
            O_ATTN_START <= 1'b0;
            O_ERR        <= 1'b0;
            case (state)
                S_LOAD: begin
                    O_BUSY <= 1'b0;
                    if (frame_ok) begin
                        state        <= S_START;
                        rdy_q        <= 1'b0;
                        O_ATTN_START <= 1'b1;
                        O_BUSY       <= 1'b1;
                    end else begin
                        rdy_q <= 1'b1;
                        O_ERR <= frame_bad;
                    end
                end
                S_START: begin
                    state  <= S_WAIT;
                    rdy_q  <= 1'b0;
                    O_BUSY <= 1'b1;
                end
                S_WAIT: begin
                    // level input: only a fresh rising edge releases the matrices
                    if (I_ATTN_DONE && !done_d) begin
                        state  <= S_LOAD;
                        rdy_q  <= 1'b1;
                        O_BUSY <= 1'b0;
                    end else begin
                        rdy_q  <= 1'b0;
                        O_BUSY <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_LOAD;
                    rdy_q  <= 1'b0;
                    O_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule
